fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Controller for the fetch stage. It owns the program counter and sequences instruction fetch, sets the F/D pipeline register enable and flush, and handles instruction-memory wait states. It also handles decode stalls, execute-stage redirects, and a one-entry holding buffer for instructions returned while decode is stalled. It sits between the hazard unit / execute stage and the PC register, instruction memory and F/D register.

Parameters:
XLEN, 32, address and instruction width
RESET_PC, 32'h0000_0000, PC value loaded on reset
BOOT_CYCLES, 2, idle cycles after reset release before the first fetch (≥1)
CNT_W, 16, width of fetch counter

Ports:
clk  input  1  clock, all state changes on rising edge
rst  input  1  asynchronous, active-low reset
stall_D  input  1  decode stall request from hazard unit
redir_E  input  1  taken branch/jump from execute
redir_pc_E  input  XLEN  redirect target, valid when redir_E=1
imem_ready  input  1  instruction memory returns instr_in this cycle
instr_in  input  XLEN  instruction-memory read data
pc_F  output  XLEN  current fetch address (registered)
imem_req  output  1  fetch request to instruction memory
fd_we  output  1  F/D register load enable
fd_flush  output  1  F/D register clear (bubble, instr 32'h0)
de_flush  output  1  D/E register clear
instr_F  output  XLEN  instruction to F/D register (memory or buffer)
state_o  output  2  FSM state, debug
fetch_cnt  output  CNT_W  count of instructions accepted into F/D

Behaviour:
- States: BOOT=0, RUN=1, WAIT=2, HOLD=3. rst=0 forces asynchronously:
  - state=BOOT, pc_F=RESET_PC, boot counter=0, fetch_cnt=0, buffer=0.
- Combinational outputs default each cycle: imem_req=0, fd_we=0, fd_flush=0, de_flush=0, instr_F=instr_in.
- BOOT:
  - fd_flush=1, imem_req=0.
  - Counter increments each cycle; at BOOT_CYCLES-1 go to RUN. pc_F unchanged.
  - redir_E is ignored.
- RUN: imem_req=1. Priority redirect > stall > memory wait:
  - redir_E=1: pc_F<=redir_pc_E, fd_flush=1, de_flush=1, stay RUN.
  - stall_D=1: pc_F held, fd_we=0, stay RUN. The same address is re-requested.
  - imem_ready=0: pc_F held, fd_flush=1 (bubble), go to WAIT.
  - Otherwise: fd_we=1, pc_F<=pc_F+4, fetch_cnt+1.
- WAIT: imem_req=1, pc_F held.
  - redir_E=1: pc_F<=redir_pc_E, fd_flush=1, de_flush=1, go to RUN. Any in-flight return is discarded.
  - imem_ready=1 and stall_D=0: fd_we=1, pc_F<=pc_F+4, fetch_cnt+1, go to RUN.
  - imem_ready=1 and stall_D=1: buffer<=instr_in, fd_we=0, go to HOLD.
  - imem_ready=0: fd_flush=1 unless stall_D=1, in which case fd_we=0 and F/D holds. Stay in WAIT.
- HOLD: imem_req=0, instr_F=buffer, pc_F held.
  - redir_E=1: same as redirect in RUN, go to RUN, buffer dropped.
  - stall_D=0: fd_we=1, pc_F<=pc_F+4, fetch_cnt+1, go to RUN.
  - Otherwise stay in HOLD.
- fd_we and fd_flush are never both 1. If a flush and a load both apply, the flush wins and fd_we=0.
- PC arithmetic is modulo 2^XLEN: 32'hFFFF_FFFC+4 wraps to 0. redir_pc_E is loaded unmodified, with no alignment check.
- fetch_cnt wraps at 2^CNT_W-1 → 0.
- Reset asserted in any state aborts immediately. No request is issued until BOOT completes again.

Test Plan:
1. Reset release, RESET_PC=0, imem_ready=1 constant, no stall/redirect.
   -> state_o=0 for 2 cycles, fd_flush=1.
   -> Then pc_F=0,4,8,12 on consecutive cycles, fd_we=1, fetch_cnt=1,2,3.
2. In RUN at pc_F=8, stall_D=1 for 3 cycles.
   -> pc_F stays 8 and fd_we=0 for 3 cycles. Next cycle pc_F=12, fetch_cnt +1 only once.
3. At pc_F=16, imem_ready=0 for 2 cycles, then 1 with instr_in=32'h00A0_0093.
   -> fd_flush=1 for 2 cycles, state_o=2. Then fd_we=1, instr_F=32'h00A0_0093, pc_F=20, state_o=1.
4. In RUN, redir_E=1 with redir_pc_E=32'h100 and stall_D=1 in the same cycle.
   -> Redirect wins: next pc_F=32'h100, fd_flush=1, de_flush=1, fetch_cnt unchanged.
5. In WAIT, imem_ready=1 with instr_in=32'hDEAD_BEEF and stall_D=1 for 2 cycles.
   -> state_o=3, instr_F=32'hDEAD_BEEF held.
   -> On stall_D=0: fd_we=1, pc_F advances by 4, state_o=1.
6. In WAIT with pc_F=32'h40, assert rst=0 mid-cycle.
   -> Without a clock edge: state_o=0, pc_F=RESET_PC, fetch_cnt=0, imem_req=0.
   -> After release, the BOOT sequence repeats. Separately, pc_F=32'hFFFF_FFFC advancing → 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the PC, sequences instruction fetch, drives the
// F/D enable/flush, absorbs memory wait states and buffers one instruction under stall.
module fetch_sequencer #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int unsigned     BOOT_CYCLES = 2,
    parameter int unsigned     CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_D,
    input  logic             redir_E,
    input  logic [XLEN-1:0]  redir_pc_E,
    input  logic             imem_ready,
    input  logic [XLEN-1:0]  instr_in,
    output logic [XLEN-1:0]  pc_F,
    output logic             imem_req,
    output logic             fd_we,
    output logic             fd_flush,
    output logic             de_flush,
    output logic [XLEN-1:0]  instr_F,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] fetch_cnt
);

    localparam int unsigned BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t            state, state_d;
    logic [BOOT_W-1:0] boot_cnt, boot_d;
    logic [XLEN-1:0]   buffer, buf_d;
    logic [XLEN-1:0]   pc_d;
    logic [CNT_W-1:0]  cnt_d;
    logic              take_redir;

    assign state_o = state;

    // Next-state, PC/counter update and per-cycle pipeline controls.
    always_comb begin
        state_d    = state;
        boot_d     = boot_cnt;
        buf_d      = buffer;
        pc_d       = pc_F;
        cnt_d      = fetch_cnt;
        take_redir = 1'b0;
        imem_req   = 1'b0;
        fd_we      = 1'b0;
        fd_flush   = 1'b0;
        de_flush   = 1'b0;
        instr_F    = instr_in;

        case (state)
            BOOT: begin
                fd_flush = 1'b1;
                boot_d   = boot_cnt + BOOT_W'(1);
                if (boot_cnt == BOOT_LAST) begin
                    state_d = RUN;
                    boot_d  = '0;
                end
            end
            RUN: begin
                imem_req = 1'b1;
                if (redir_E) begin
                    take_redir = 1'b1;
                end else if (stall_D) begin
                    fd_we = 1'b0;
                end else if (!imem_ready) begin
                    fd_flush = 1'b1;
                    state_d  = WAIT;
                end else begin
                    fd_we = 1'b1;
                end
            end
            WAIT: begin
                imem_req = 1'b1;
                if (redir_E) begin
                    take_redir = 1'b1;
                    state_d    = RUN;
                end else if (imem_ready) begin
                    if (!stall_D) begin
                        fd_we   = 1'b1;
                        state_d = RUN;
                    end else begin
                        buf_d   = instr_in;
                        state_d = HOLD;
                    end
                end else if (!stall_D) begin
                    fd_flush = 1'b1;
                end
            end
            HOLD: begin
                instr_F = buffer;
                if (redir_E) begin
                    take_redir = 1'b1;
                    buf_d      = '0;
                    state_d    = RUN;
                end else if (!stall_D) begin
                    fd_we   = 1'b1;
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase

        // A redirect squashes both F/D and D/E; it never coincides with a load.
        if (take_redir) begin
            pc_d     = redir_pc_E;
            fd_flush = 1'b1;
            de_flush = 1'b1;
            fd_we    = 1'b0;
        end else if (fd_we) begin
            pc_d  = pc_F + XLEN'(4);
            cnt_d = fetch_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= BOOT;
            boot_cnt  <= '0;
            buffer    <= '0;
            pc_F      <= RESET_PC;
            fetch_cnt <= '0;
        end else begin
            state     <= state_d;
            boot_cnt  <= boot_d;
            buffer    <= buf_d;
            pc_F      <= pc_d;
            fetch_cnt <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus random traffic
// against an event-level reference model of the fetch stage.
module tb_fetch_sequencer;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned CNT_W       = 16;
    localparam int unsigned BOOT_CYCLES = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             stall_D, redir_E, imem_ready;
    logic [XLEN-1:0]  redir_pc_E, instr_in;
    logic [XLEN-1:0]  pc_F, instr_F;
    logic             imem_req, fd_we, fd_flush, de_flush;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] fetch_cnt;

    int checks = 0;
    int errors = 0;

    fetch_sequencer #(
        .XLEN(XLEN), .RESET_PC(32'h0000_0000), .BOOT_CYCLES(BOOT_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .stall_D(stall_D), .redir_E(redir_E),
        .redir_pc_E(redir_pc_E), .imem_ready(imem_ready), .instr_in(instr_in),
        .pc_F(pc_F), .imem_req(imem_req), .fd_we(fd_we), .fd_flush(fd_flush),
        .de_flush(de_flush), .instr_F(instr_F), .state_o(state_o), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: boot countdown, an outstanding-miss flag, and a queue
    // holding the instruction parked while decode is stalled.
    int               m_boot_left;
    bit               m_waiting;
    logic [XLEN-1:0]  m_held[$];
    logic [XLEN-1:0]  m_pc;
    logic [CNT_W-1:0] m_cnt;
    logic             e_req, e_we, e_flush, e_de;
    logic [XLEN-1:0]  e_instr;
    logic [1:0]       e_state;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_boot_left = BOOT_CYCLES;
        m_waiting   = 1'b0;
        m_held.delete();
        m_pc        = 32'h0000_0000;
        m_cnt       = '0;
    endtask

    task automatic model_outputs();
        e_req = 0; e_we = 0; e_flush = 0; e_de = 0; e_instr = instr_in;
        if (m_boot_left > 0) begin
            e_state = 2'd0;
            e_flush = 1;
        end else if (m_held.size() > 0) begin
            e_state = 2'd3;
            e_instr = m_held[0];
            if (redir_E) begin e_flush = 1; e_de = 1; end
            else if (!stall_D) e_we = 1;
        end else begin
            e_state = m_waiting ? 2'd2 : 2'd1;
            e_req   = 1;
            if (redir_E) begin
                e_flush = 1; e_de = 1;
            end else if (imem_ready && !stall_D) begin
                e_we = 1;
            end else if (!imem_ready && !stall_D) begin
                e_flush = 1;
            end
        end
    endtask

    task automatic model_update();
        if (m_boot_left > 0) begin
            m_boot_left--;
        end else if (redir_E) begin
            m_pc = redir_pc_E; m_waiting = 0; m_held.delete();
        end else if (e_we) begin
            m_pc = m_pc + 32'd4; m_cnt = m_cnt + 16'd1; m_waiting = 0; m_held.delete();
        end else if (m_held.size() == 0 && !m_waiting && !stall_D && !imem_ready) begin
            m_waiting = 1;
        end else if (m_held.size() == 0 && m_waiting && imem_ready && stall_D) begin
            m_held.push_back(instr_in); m_waiting = 0;
        end
    endtask

    task automatic compare_all();
        model_outputs();
        chk("pc_F", pc_F, m_pc);
        chk("state_o", 32'(state_o), 32'(e_state));
        chk("fetch_cnt", 32'(fetch_cnt), 32'(m_cnt));
        chk("imem_req", 32'(imem_req), 32'(e_req));
        chk("fd_we", 32'(fd_we), 32'(e_we));
        chk("fd_flush", 32'(fd_flush), 32'(e_flush));
        chk("de_flush", 32'(de_flush), 32'(e_de));
        chk("instr_F", instr_F, e_instr);
    endtask

    // One clock: drive at negedge, check mid-cycle, advance model at posedge.
    task automatic cycle(input bit st, input bit rd, input logic [XLEN-1:0] rpc,
                         input bit rdy, input logic [XLEN-1:0] ins);
        stall_D = st; redir_E = rd; redir_pc_E = rpc; imem_ready = rdy; instr_in = ins;
        #1;
        compare_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    logic [CNT_W-1:0] saved_cnt;

    initial begin
        rst = 1'b0; stall_D = 0; redir_E = 0; redir_pc_E = '0; imem_ready = 1; instr_in = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Boot then steady fetch
        cycle(0, 0, 0, 1, 32'h1111_0001);
        cycle(0, 0, 0, 1, 32'h1111_0002);
        cycle(0, 0, 0, 1, 32'h1111_0003);
        cycle(0, 0, 0, 1, 32'h1111_0004);
        chk("t1_pc8", pc_F, 32'd8);
        chk("t1_cnt2", 32'(fetch_cnt), 32'd2);

        // Decode stall holds the PC
        repeat (3) cycle(1, 0, 0, 1, $urandom);
        chk("t2_pc_held", pc_F, 32'd8);
        cycle(0, 0, 0, 1, 32'h2222_0001);
        cycle(0, 0, 0, 1, 32'h2222_0002);
        chk("t2_pc16", pc_F, 32'd16);
        chk("t2_cnt4", 32'(fetch_cnt), 32'd4);

        // Memory wait states
        cycle(0, 0, 0, 0, 32'hBAD0_0000);
        cycle(0, 0, 0, 0, 32'hBAD0_0001);
        chk("t3_wait_state", 32'(state_o), 32'd2);
        cycle(0, 0, 0, 1, 32'h00A0_0093);
        chk("t3_pc20", pc_F, 32'd20);
        chk("t3_run", 32'(state_o), 32'd1);

        // Redirect beats stall
        saved_cnt = fetch_cnt;
        cycle(1, 1, 32'h0000_0100, 1, 32'h3333_0000);
        chk("t4_pc100", pc_F, 32'h0000_0100);
        chk("t4_cnt_same", 32'(fetch_cnt), 32'(saved_cnt));

        // Return under stall parks in HOLD
        cycle(0, 0, 0, 0, 32'h0);
        cycle(1, 0, 0, 1, 32'hDEAD_BEEF);
        cycle(1, 0, 0, 0, 32'h5555_5555);
        chk("t5_hold", 32'(state_o), 32'd3);
        chk("t5_instr", instr_F, 32'hDEAD_BEEF);
        cycle(0, 0, 0, 0, 32'h6666_6666);
        chk("t5_pc104", pc_F, 32'h0000_0104);
        chk("t5_run", 32'(state_o), 32'd1);

        // PC wraps modulo 2^32
        cycle(0, 1, 32'hFFFF_FFFC, 1, 32'h0);
        cycle(0, 0, 0, 1, 32'h7777_0000);
        chk("t6_wrap", pc_F, 32'h0000_0000);

        // Asynchronous reset out of WAIT
        cycle(0, 1, 32'h0000_0040, 1, 32'h0);
        cycle(0, 0, 0, 0, 32'h0);
        chk("t6_wait", 32'(state_o), 32'd2);
        chk("t6_pc40", pc_F, 32'h0000_0040);
        #2 rst = 1'b0;
        #1;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_pc", pc_F, 32'h0000_0000);
        chk("rst_cnt", 32'(fetch_cnt), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Boot again, then random traffic
        cycle(0, 1, 32'h0000_0200, 1, 32'h0);
        cycle(0, 1, 32'h0000_0300, 1, 32'h0);
        chk("reboot_pc", pc_F, 32'h0000_0000);
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom,
                  $urandom_range(0, 9) < 6, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
